adder_bist: RTL and testbench

Built-in self-test initiator for the `adder` block. It generates pseudo-random operand transactions (`a`, `b`, `valid`) on the adder's input side. It tracks each valid transaction's expected sum through a latency-matched pipeline and compares it against the adder's returned `sum`. It sits beside `adder` in the datapath and takes over the stimulus/scoreboard role in silicon and FPGA builds, reporting pass/fail counts to a control register block.

---
 rtl/adder_pkg.sv | 16 +
 rtl/bist_lfsr.sv | 29 ++
 rtl/adder_bist.sv | 155 +++++++++++++++
 tb/tb_adder_bist.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_pkg.sv
// adder_pkg: shared state, LFSR and scoreboard types for the adder BIST
package adder_pkg;
    localparam int BIST_OP_W = 16;
    localparam int BIST_SUM_W = BIST_OP_W + 1;
    localparam logic [31:0] BIST_LFSR_TAPS = 32'h80200003;
    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} bist_state_e;
    typedef struct packed {
        logic valid;
        logic [BIST_OP_W-1:0] a;
        logic [BIST_OP_W-1:0] b;
        logic [BIST_SUM_W-1:0] expected;
    } bist_pend_t;
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/bist_lfsr.sv
// bist_lfsr: 32-bit Galois LFSR with seed load (zero seed becomes 1) and per-cycle advance; exposes the operands of its next value
module bist_lfsr import adder_pkg::*; #(
    parameter int OP_BITS = 8
) (
    input logic clk,
    input logic rst_n,
    input logic load,
    input logic adv,
    input logic [31:0] seed,
    output logic [BIST_OP_W-1:0] nxt_a,
    output logic [BIST_OP_W-1:0] nxt_b,
    output logic nxt_valid
);
    logic [31:0] lfsr;
    logic [31:0] nxt;
    // Next state: load wins over advance; operands are sliced from the value about to be stored
    always_comb begin
        nxt = load ? ((seed == 32'd0) ? 32'd1 : seed)
            : adv ? ((lfsr >> 1) ^ (lfsr[0] ? BIST_LFSR_TAPS : 32'd0)) : lfsr;
        nxt_a = BIST_OP_W'(nxt[OP_BITS-1:0]);
        nxt_b = BIST_OP_W'(nxt[16+OP_BITS-1:16]);
        nxt_valid = nxt[31];
    end
    // LFSR state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) lfsr <= 32'd1;
        else lfsr <= nxt;
    end
endmodule

// File: rtl/adder_bist.sv
// adder_bist: pseudo-random stimulus and latency-matched scoreboard for the adder; ADDER_BIST_ERR_LOG_EN builds first-failure capture
module adder_bist import adder_pkg::*; #(
    parameter int WIDTH = 32,
    parameter int OP_BITS = 8,
    parameter int LATENCY = 1
) (
    input logic clk,
    input logic rst_n,
    input logic start,
    input logic [15:0] num_trans,
    input logic [31:0] seed,
    output logic [WIDTH-1:0] a,
    output logic [WIDTH-1:0] b,
    output logic valid,
    input logic [WIDTH:0] sum,
    output logic busy,
    output logic done,
    output logic [15:0] txn_count,
    output logic [15:0] pass_count,
    output logic [15:0] fail_count,
    output logic [WIDTH-1:0] err_a,
    output logic [WIDTH-1:0] err_b,
    output logic [WIDTH:0] err_exp,
    output logic [WIDTH:0] err_got
);
    localparam int DW = $clog2(LATENCY + 1);
    bist_state_e state;
    logic [15:0] issue_cnt;
    logic [DW-1:0] drain_cnt;
    logic [BIST_OP_W-1:0] op_a, op_b, lfsr_a, lfsr_b;
    logic lfsr_valid, accept, issuing, check, hit;
    bist_pend_t issue;
    bist_pend_t pend [LATENCY];

    assign accept = start && (state == IDLE || state == DONE);
    assign issuing = accept ? (num_trans != 16'd0) : (state == RUN && issue_cnt != 16'd1);
    assign a = WIDTH'(op_a);
    assign b = WIDTH'(op_b);
    assign check = pend[LATENCY-1].valid;
    assign hit = sum === (WIDTH+1)'(pend[LATENCY-1].expected);

    bist_lfsr #(.OP_BITS(OP_BITS)) u_lfsr (
        .clk(clk),
        .rst_n(rst_n),
        .load(accept),
        .adv(state == RUN),
        .seed(seed),
        .nxt_a(lfsr_a),
        .nxt_b(lfsr_b),
        .nxt_valid(lfsr_valid)
    );

    // Control FSM; operands are registered so the last RUN edge already drives zeros
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
            issue_cnt <= '0;
            drain_cnt <= '0;
            op_a <= '0;
            op_b <= '0;
            valid <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
        end else begin
            op_a <= issuing ? lfsr_a : '0;
            op_b <= issuing ? lfsr_b : '0;
            valid <= issuing & lfsr_valid;
            if (accept) begin
                state <= (num_trans == 16'd0) ? DRAIN : RUN;
                issue_cnt <= num_trans;
                drain_cnt <= DW'(LATENCY - 1);
                busy <= 1'b1;
                done <= 1'b0;
            end else begin
                case (state)
                    RUN: begin
                        issue_cnt <= issue_cnt - 16'd1;
                        if (issue_cnt == 16'd1) state <= DRAIN;
                    end
                    DRAIN: begin
                        drain_cnt <= drain_cnt - DW'(1);
                        if (drain_cnt == '0) begin
                            state <= DONE;
                            busy <= 1'b0;
                            done <= 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    // Pending entry for the transaction currently on the adder inputs
    always_comb begin
        issue.valid = valid;
        issue.a = op_a;
        issue.b = op_b;
        issue.expected = {1'b0, op_a} + {1'b0, op_b};
    end

    // Latency-matched shift register of expected results
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < LATENCY; i++) pend[i] <= '0;
        end else begin
            pend[0] <= issue;
            for (int i = 1; i < LATENCY; i++) pend[i] <= pend[i-1];
        end
    end

    // Saturating scoreboard counters, cleared when a run is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            txn_count <= '0;
            pass_count <= '0;
            fail_count <= '0;
        end else if (accept) begin
            txn_count <= '0;
            pass_count <= '0;
            fail_count <= '0;
        end else if (check) begin
            txn_count <= sat_inc(txn_count);
            pass_count <= hit ? sat_inc(pass_count) : pass_count;
            fail_count <= hit ? fail_count : sat_inc(fail_count);
        end
    end

`ifdef ADDER_BIST_ERR_LOG_EN
    // Hold the first miscompare of the run until the next accepted start
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_a <= '0;
            err_b <= '0;
            err_exp <= '0;
            err_got <= '0;
        end else if (accept) begin
            err_a <= '0;
            err_b <= '0;
            err_exp <= '0;
            err_got <= '0;
        end else if (check && !hit && fail_count == 16'd0) begin
            err_a <= WIDTH'(pend[LATENCY-1].a);
            err_b <= WIDTH'(pend[LATENCY-1].b);
            err_exp <= (WIDTH+1)'(pend[LATENCY-1].expected);
            err_got <= sum;
        end
    end
`else
    assign err_a = '0;
    assign err_b = '0;
    assign err_exp = '0;
    assign err_got = '0;
`endif
endmodule

// File: tb/tb_adder_bist.sv
// tb_adder_bist: directed checks of adder_bist against correct, faulty and 3-cycle adder models
module tb_adder_bist;
    localparam logic [31:0] TAPS = 32'h80200003;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic fault = 1'b0;
    logic start1 = 1'b0, start3 = 1'b0;
    logic [15:0] num1 = '0, num3 = '0;
    logic [31:0] seed1 = '0, seed3 = '0;
    logic [31:0] a1, b1, a3, b3, ea1, eb1, ea3, eb3;
    logic v1, v3, busy1, busy3, done1, done3;
    logic [32:0] s1, sum1, sum3, ee1, eg1, ee3, eg3;
    logic [32:0] p3 [3];
    logic [15:0] txn1, pass1, fail1, txn3, pass3, fail3;
    int vectors = 0;
    int errors = 0;
    int cyc, bus_v, nv, nodd;
    logic [7:0] fa, fb;
    logic [32:0] fexp;

    always #5 clk = ~clk;

    always @(posedge clk) begin
        s1 <= {1'b0, a1} + {1'b0, b1};
        p3[0] <= {1'b0, a3} + {1'b0, b3};
        p3[1] <= p3[0];
        p3[2] <= p3[1];
    end
    assign sum1 = fault ? (s1 & ~33'd1) : s1;
    assign sum3 = p3[2];

    adder_bist #(.WIDTH(32), .OP_BITS(8), .LATENCY(1)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start1), .num_trans(num1), .seed(seed1),
        .a(a1), .b(b1), .valid(v1), .sum(sum1), .busy(busy1), .done(done1),
        .txn_count(txn1), .pass_count(pass1), .fail_count(fail1),
        .err_a(ea1), .err_b(eb1), .err_exp(ee1), .err_got(eg1)
    );

    adder_bist #(.WIDTH(32), .OP_BITS(8), .LATENCY(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .start(start3), .num_trans(num3), .seed(seed3),
        .a(a3), .b(b3), .valid(v3), .sum(sum3), .busy(busy3), .done(done3),
        .txn_count(txn3), .pass_count(pass3), .fail_count(fail3),
        .err_a(ea3), .err_b(eb3), .err_exp(ee3), .err_got(eg3)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        vectors++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain1(output int c, output int bv);
        c = 0;
        bv = 0;
        while (busy1 && c < 2000) begin
            c++;
            bv += int'(v1);
            tick();
        end
    endtask

    // Reference: walk the LFSR, count valid issues and those whose sum is odd (hit by a stuck-at-0 sum[0])
    function automatic void model(input logic [31:0] seed, input int cnt, output int v, output int odd,
                                  output logic [7:0] first_a, output logic [7:0] first_b);
        logic [31:0] l;
        l = (seed == 32'd0) ? 32'd1 : seed;
        v = 0;
        odd = 0;
        first_a = '0;
        first_b = '0;
        for (int i = 0; i < cnt; i++) begin
            if (l[31]) begin
                v++;
                if (l[0] ^ l[16]) begin
                    if (odd == 0) begin
                        first_a = l[7:0];
                        first_b = l[23:16];
                    end
                    odd++;
                end
            end
            l = (l >> 1) ^ (l[0] ? TAPS : 32'd0);
        end
    endfunction

    initial begin
        // Reset values
        tick();
        tick();
        chk("rst_a", a1, 0);
        chk("rst_b", b1, 0);
        chk("rst_valid", v1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_done", done1, 0);
        chk("rst_txn", txn1, 0);
        chk("rst_pass", pass1, 0);
        chk("rst_fail", fail1, 0);
        chk("rst_err_exp", ee1, 0);
        chk("rst_busy3", busy3, 0);
        rst_n = 1'b1;
        tick();

        // Correct adder, 50 issues from seed ACE1, with an ignored start mid-run
        num1 = 16'd50;
        seed1 = 32'hACE1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        num1 = 16'd3;
        seed1 = 32'd9;
        cyc = 0;
        bus_v = 0;
        while (busy1 && cyc < 2000) begin
            if (cyc == 0) begin
                chk("t1_a", a1, 32'hE1);
                chk("t1_b", b1, 32'h00);
                chk("t1_valid", v1, 0);
            end
            if (cyc == 1) begin
                chk("t2_a", a1, 32'h73);
                chk("t2_b", b1, 32'h20);
                chk("t2_valid", v1, 1);
            end
            if (cyc == 2) begin
                chk("t3_a", a1, 32'h3A);
                chk("t3_b", b1, 32'h30);
                chk("t3_valid", v1, 1);
            end
            cyc++;
            bus_v += int'(v1);
            start1 = (cyc == 10);
            tick();
        end
        start1 = 1'b0;
        model(32'hACE1, 50, nv, nodd, fa, fb);
        chk("run50_busy_cycles", cyc, 51);
        chk("run50_bus_valid", bus_v, nv);
        chk("run50_txn", txn1, nv);
        chk("run50_pass", pass1, nv);
        chk("run50_fail", fail1, 0);
        chk("run50_done", done1, 1);
        chk("run50_idle_valid", v1, 0);
        chk("run50_idle_a", a1, 0);

        // Faulty adder: sum[0] stuck at 0
        fault = 1'b1;
        num1 = 16'd100;
        seed1 = 32'h12345678;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        drain1(cyc, bus_v);
        model(32'h12345678, 100, nv, nodd, fa, fb);
        fexp = {25'd0, fa} + {25'd0, fb};
        chk("fault_busy_cycles", cyc, 101);
        chk("fault_txn", txn1, nv);
        chk("fault_fail", fail1, nodd);
        chk("fault_pass", pass1, nv - nodd);
        chk("fault_sum_counts", 64'(pass1) + 64'(fail1), nv);
`ifdef ADDER_BIST_ERR_LOG_EN
        chk("err_a", ea1, fa);
        chk("err_b", eb1, fb);
        chk("err_exp", ee1, fexp);
        chk("err_got", eg1, fexp & ~33'd1);
`else
        chk("err_a_tied", ea1, 0);
        chk("err_got_tied", eg1, 0);
`endif
        fault = 1'b0;

        // Zero-length run from DONE; a start during DRAIN is ignored
        num1 = 16'd0;
        start1 = 1'b1;
        tick();
        num1 = 16'd5;
        chk("zero_busy", busy1, 1);
        chk("zero_done", done1, 0);
        chk("zero_valid", v1, 0);
        chk("zero_txn_cleared", txn1, 0);
        chk("zero_fail_cleared", fail1, 0);
        chk("zero_err_cleared", ee1, 0);
        tick();
        start1 = 1'b0;
        chk("zero_busy_end", busy1, 0);
        chk("zero_done_end", done1, 1);
        tick();
        chk("zero_done_hold", done1, 1);
        chk("zero_busy_hold", busy1, 0);
        chk("zero_pass", pass1, 0);

        // LATENCY=3, 255+255 forced through the seed
        num3 = 16'd1;
        seed3 = 32'h80FF00FF;
        start3 = 1'b1;
        tick();
        start3 = 1'b0;
        chk("lat3_a", a3, 32'hFF);
        chk("lat3_b", b3, 32'hFF);
        chk("lat3_valid", v3, 1);
        chk("lat3_busy0", busy3, 1);
        for (int k = 1; k <= 4; k++) begin
            tick();
            chk("lat3_txn", txn3, (k == 4) ? 1 : 0);
            chk("lat3_busy", busy3, (k == 4) ? 0 : 1);
        end
        chk("lat3_pass", pass3, 1);
        chk("lat3_fail", fail3, 0);
        chk("lat3_done", done3, 1);

        // Asynchronous reset mid-run, then a clean run from seed 0
        num1 = 16'd50;
        seed1 = 32'hACE1;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        repeat (6) tick();
        chk("pre_rst_txn", txn1 != 16'd0, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_busy", busy1, 0);
        chk("mid_rst_a", a1, 0);
        chk("mid_rst_valid", v1, 0);
        chk("mid_rst_txn", txn1, 0);
        chk("mid_rst_pass", pass1, 0);
        tick();
        rst_n = 1'b1;
        tick();
        num1 = 16'd20;
        seed1 = 32'd0;
        start1 = 1'b1;
        tick();
        start1 = 1'b0;
        chk("seed0_a", a1, 1);
        chk("seed0_valid", v1, 0);
        drain1(cyc, bus_v);
        model(32'd0, 20, nv, nodd, fa, fb);
        chk("post_rst_busy_cycles", cyc, 21);
        chk("post_rst_txn", txn1, nv);
        chk("post_rst_pass", pass1, nv);
        chk("post_rst_fail", fail1, 0);
        chk("post_rst_done", done1, 1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
